// File: rtl/exc_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// exc_arbiter_pkg
// Shared definitions for the MEM-stage exception arbiter:
//   - exception codes written to CP0 Cause.ExcCode
//   - CP0 register addresses that the arbiter forwards from WB
//   - exc_flags bit positions
//   - FSM state encoding
//   - helpers for interrupt detection and priority selection
// -----------------------------------------------------------------------------
package exc_arbiter_pkg;

  // Exception codes driven on excepttype_o. Zero means "no exception".
  localparam logic [31:0] EXC_CODE_NONE     = 32'h0000_0000;
  localparam logic [31:0] EXC_CODE_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_CODE_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_CODE_INVALID  = 32'h0000_000a;
  localparam logic [31:0] EXC_CODE_OVERFLOW = 32'h0000_000c;
  localparam logic [31:0] EXC_CODE_TRAP     = 32'h0000_000d;
  localparam logic [31:0] EXC_CODE_ERET     = 32'h0000_000e;

  // CP0 register numbers.
  localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

  // Cause bits that software may write: IP[1:0] (9:8), IV (23), WP (22).
  // Everything else in Cause is hardware-owned and never forwarded.
  localparam logic [31:0] CAUSE_SW_MASK = 32'h00C0_0300;

  // Bit positions inside exc_flags_i.
  localparam int unsigned FLAG_SYSCALL  = 4;
  localparam int unsigned FLAG_INVALID  = 3;
  localparam int unsigned FLAG_TRAP     = 2;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_ERET     = 0;

  // FSM state encoding.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_e;

  // Interrupt pending: interrupts enabled (IE=1), not already at exception
  // level (EXL=0), and at least one pending line that is unmasked.
  function automatic logic exc_int_pending(input logic [31:0] status,
                                           input logic [31:0] cause);
    return status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
  endfunction

  // Fixed-priority selection, highest first:
  // interrupt, syscall, invalid_inst, trap, overflow, eret.
  function automatic logic [31:0] exc_select(input logic       int_pending,
                                             input logic [4:0] flags);
    logic [31:0] code;
    code = EXC_CODE_NONE;
    if (int_pending)                 code = EXC_CODE_INT;
    else if (flags[FLAG_SYSCALL])    code = EXC_CODE_SYSCALL;
    else if (flags[FLAG_INVALID])    code = EXC_CODE_INVALID;
    else if (flags[FLAG_TRAP])       code = EXC_CODE_TRAP;
    else if (flags[FLAG_OVERFLOW])   code = EXC_CODE_OVERFLOW;
    else if (flags[FLAG_ERET])       code = EXC_CODE_ERET;
    return code;
  endfunction

endpackage

// File: rtl/exc_arbiter_if.sv
// -----------------------------------------------------------------------------
// exc_arbiter_if
// Bundles the MEM-stage / CP0 side signals of the exception arbiter.
//   slave  : seen by exc_arbiter (MEM/CP0/WB inputs in, CP0/flush outputs out)
//   master : seen by the pipeline / testbench that drives the arbiter
// Signal names keep their _i/_o suffix as seen from the arbiter.
// -----------------------------------------------------------------------------
interface exc_arbiter_if;

  // MEM-stage instruction
  logic        stall_i;
  logic        inst_valid_i;
  logic [4:0]  exc_flags_i;        // {syscall, invalid_inst, trap, overflow, eret}
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;

  // CP0 architectural state
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;

  // CP0 write pending in WB
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;

  // Results
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  modport slave (
    input  stall_i, inst_valid_i, exc_flags_i, pc_i, is_in_delayslot_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    output flush_o, new_pc_o, busy_o
  );

  modport master (
    output stall_i, inst_valid_i, exc_flags_i, pc_i, is_in_delayslot_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    input  flush_o, new_pc_o, busy_o
  );

endinterface

// File: rtl/exc_arbiter_cp0_fwd.sv
// -----------------------------------------------------------------------------
// exc_cp0_fwd
// Purely combinational bypass of a CP0 write still sitting in WB, so the
// arbiter decides on the values CP0 will hold once that write retires.
// Ports:
//   cp0_status_i/cp0_cause_i/cp0_epc_i : current CP0 registers
//   wb_cp0_we_i/waddr_i/data_i         : pending WB write
//   status_o/cause_o/epc_o             : forwarded values
// Only the software-writable Cause bits are taken from WB; the rest of Cause
// (including hardware interrupt lines) always comes from CP0.
// -----------------------------------------------------------------------------
module exc_cp0_fwd
  import exc_arbiter_pkg::*;
(
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  always_comb begin
    status_o = cp0_status_i;
    cause_o  = cp0_cause_i;
    epc_o    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        CP0_ADDR_STATUS: status_o = wb_cp0_data_i;
        CP0_ADDR_CAUSE:  cause_o  = (cp0_cause_i & ~CAUSE_SW_MASK) |
                                    (wb_cp0_data_i & CAUSE_SW_MASK);
        CP0_ADDR_EPC:    epc_o    = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exc_arbiter.sv
// -----------------------------------------------------------------------------
// exc_arbiter
// MEM-stage exception arbiter. Picks the highest-priority exception of the
// current instruction, reports it to CP0 as a one-cycle pulse and flushes the
// pipeline for FLUSH_CYCLES cycles while redirecting fetch.
// Parameters:
//   EXC_VECTOR   : redirect target for every exception except ERET
//   FLUSH_CYCLES : flush window length, 1..15
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : exc_arbiter_if.slave (MEM instruction, CP0 state, WB write,
//              CP0 report, flush/redirect, busy)
// Behaviour:
//   IDLE  : an exception is accepted when the instruction is valid and not
//           stalled; the report and redirect are registered and appear on
//           the following cycle.
//   FLUSH : all inputs are ignored (new candidates are dropped, not queued);
//           returns to IDLE after FLUSH_CYCLES cycles.
// -----------------------------------------------------------------------------
module exc_arbiter
  import exc_arbiter_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  exc_arbiter_if.slave  bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  // Forwarded CP0 view
  logic [31:0] status_fwd;
  logic [31:0] cause_fwd;
  logic [31:0] epc_fwd;

  exc_cp0_fwd u_cp0_fwd (
    .cp0_status_i   (bus.cp0_status_i),
    .cp0_cause_i    (bus.cp0_cause_i),
    .cp0_epc_i      (bus.cp0_epc_i),
    .wb_cp0_we_i    (bus.wb_cp0_we_i),
    .wb_cp0_waddr_i (bus.wb_cp0_waddr_i),
    .wb_cp0_data_i  (bus.wb_cp0_data_i),
    .status_o       (status_fwd),
    .cause_o        (cause_fwd),
    .epc_o          (epc_fwd)
  );

  // State and registered outputs
  exc_state_e  state_q;
  logic [3:0]  flush_cnt_q;
  logic [31:0] excepttype_q;
  logic [31:0] inst_addr_q;
  logic        delayslot_q;
  logic        flush_q;
  logic [31:0] new_pc_q;

  // Candidate selection
  logic        int_pending;
  logic        cand_window;
  logic [31:0] exc_code_d;
  logic        accept_d;
  logic [31:0] new_pc_d;

  assign int_pending = exc_int_pending(status_fwd, cause_fwd);

  // A candidate only exists for a valid, unstalled instruction while idle.
  // Gating the interrupt here too keeps it off bubbles.
  assign cand_window = bus.inst_valid_i & ~bus.stall_i & (state_q == ST_IDLE);
  assign exc_code_d  = cand_window ? exc_select(int_pending, bus.exc_flags_i)
                                   : EXC_CODE_NONE;
  assign accept_d    = (exc_code_d != EXC_CODE_NONE);

  // ERET returns through EPC; the forwarded value covers an mtc0 EPC in WB.
  assign new_pc_d    = (exc_code_d == EXC_CODE_ERET) ? epc_fwd : EXC_VECTOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= 4'd0;
      excepttype_q <= EXC_CODE_NONE;
      inst_addr_q  <= 32'd0;
      delayslot_q  <= 1'b0;
      flush_q      <= 1'b0;
      new_pc_q     <= 32'd0;
    end else begin
      // excepttype is a pulse: cleared every cycle unless re-armed below.
      excepttype_q <= EXC_CODE_NONE;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            state_q      <= ST_FLUSH;
            flush_cnt_q  <= FLUSH_LOAD;
            excepttype_q <= exc_code_d;
            inst_addr_q  <= bus.pc_i;
            delayslot_q  <= bus.is_in_delayslot_i;
            flush_q      <= 1'b1;
            new_pc_q     <= new_pc_d;
          end
        end
        ST_FLUSH: begin
          // flush_cnt_q counts flush cycles left including the current one.
          if (flush_cnt_q <= 4'd1) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 4'd0;
            flush_q     <= 1'b0;
            new_pc_q    <= 32'd0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          flush_cnt_q <= 4'd0;
          flush_q     <= 1'b0;
          new_pc_q    <= 32'd0;
        end
      endcase
    end
  end

  assign bus.excepttype_o        = excepttype_q;
  assign bus.current_inst_addr_o = inst_addr_q;
  assign bus.is_in_delayslot_o   = delayslot_q;
  assign bus.flush_o             = flush_q;
  assign bus.new_pc_o            = new_pc_q;
  assign bus.busy_o              = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_exc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exc_arbiter
// Two arbiters (FLUSH_CYCLES = 1 and 3) share one stimulus stream. A
// transaction-level model tracks, per instance, how many flush cycles remain
// and which redirect address is held, and predicts every output each cycle.
// Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_exc_arbiter;

  localparam logic [31:0] VEC = 32'h0000_0020;

  logic clk;
  logic rst;

  // Shared stimulus
  logic        stall, valid, ds, we;
  logic [4:0]  flags, waddr;
  logic [31:0] pc, status, cause, epc, wdata;

  exc_arbiter_if ifa ();
  exc_arbiter_if ifb ();

  assign ifa.stall_i = stall;           assign ifb.stall_i = stall;
  assign ifa.inst_valid_i = valid;      assign ifb.inst_valid_i = valid;
  assign ifa.exc_flags_i = flags;       assign ifb.exc_flags_i = flags;
  assign ifa.pc_i = pc;                 assign ifb.pc_i = pc;
  assign ifa.is_in_delayslot_i = ds;    assign ifb.is_in_delayslot_i = ds;
  assign ifa.cp0_status_i = status;     assign ifb.cp0_status_i = status;
  assign ifa.cp0_cause_i = cause;       assign ifb.cp0_cause_i = cause;
  assign ifa.cp0_epc_i = epc;           assign ifb.cp0_epc_i = epc;
  assign ifa.wb_cp0_we_i = we;          assign ifb.wb_cp0_we_i = we;
  assign ifa.wb_cp0_waddr_i = waddr;    assign ifb.wb_cp0_waddr_i = waddr;
  assign ifa.wb_cp0_data_i = wdata;     assign ifb.wb_cp0_data_i = wdata;

  exc_arbiter #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(1)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  exc_arbiter #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(3)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          fc   [2] = '{1, 3};
  int          rem  [2] = '{0, 0};   // flush cycles left, incl. current one
  logic [31:0] hold [2] = '{32'd0, 32'd0};
  logic [31:0] e_exc[2], e_addr[2], e_npc[2];
  logic        e_ds [2], e_flush[2];
  logic        chk_addr[2];

  function automatic logic [31:0] ref_code();
    logic [31:0] st, ca;
    logic        ip;
    logic [31:0] codes [5] = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he};
    if (!valid || stall) return 32'h0;
    st = (we && waddr == 5'd12) ? wdata : status;
    ca = cause;
    if (we && waddr == 5'd13) ca = (cause & ~32'h00C00300) | (wdata & 32'h00C00300);
    ip = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
    if (ip) return 32'h1;
    for (int i = 0; i < 5; i++)
      if (flags[4 - i]) return codes[i];
    return 32'h0;
  endfunction

  task automatic model_step();
    logic [31:0] code;
    code = ref_code();
    for (int k = 0; k < 2; k++) begin
      chk_addr[k] = 1'b0;
      e_exc[k]    = 32'h0;
      if (rst) begin
        rem[k] = 0; hold[k] = 32'h0; e_addr[k] = 32'h0; e_ds[k] = 1'b0;
        chk_addr[k] = 1'b1;
      end else if (rem[k] > 0) begin
        rem[k]--;
      end else if (code != 32'h0) begin
        rem[k]      = fc[k];
        hold[k]     = (code == 32'he) ? ((we && waddr == 5'd14) ? wdata : epc) : VEC;
        e_exc[k]    = code;
        e_addr[k]   = pc;
        e_ds[k]     = ds;
        chk_addr[k] = 1'b1;
      end
      e_flush[k] = (rem[k] > 0);
      e_npc[k]   = (rem[k] > 0) ? hold[k] : 32'h0;
    end
  endtask

  task automatic check_inst(input string p, input int k,
                            input logic [31:0] exc, input logic [31:0] addr,
                            input logic dsl, input logic fl,
                            input logic [31:0] npc, input logic busy);
    check({p, ".exc"},   exc,   e_exc[k]);
    check({p, ".flush"}, 32'(fl),   32'(e_flush[k]));
    check({p, ".newpc"}, npc,   e_npc[k]);
    check({p, ".busy"},  32'(busy), 32'(e_flush[k]));
    if (chk_addr[k]) begin
      check({p, ".addr"}, addr,     e_addr[k]);
      check({p, ".ds"},   32'(dsl), 32'(e_ds[k]));
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_inst("a", 0, ifa.excepttype_o, ifa.current_inst_addr_o,
               ifa.is_in_delayslot_o, ifa.flush_o, ifa.new_pc_o, ifa.busy_o);
    check_inst("b", 1, ifb.excepttype_o, ifb.current_inst_addr_o,
               ifb.is_in_delayslot_o, ifb.flush_o, ifb.new_pc_o, ifb.busy_o);
    $display("cyc rst=%0b v=%0b st=%0b fl=%b | a exc=%h f=%0b | b exc=%h f=%0b",
             rst, valid, stall, flags, ifa.excepttype_o, ifa.flush_o,
             ifb.excepttype_o, ifb.flush_o);
  endtask

  task automatic set_idle();
    stall = 0; valid = 0; ds = 0; we = 0; flags = 5'd0; waddr = 5'd0;
    pc = 32'h0; status = 32'h0; cause = 32'h0; epc = 32'h0; wdata = 32'h0;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    cycle();
    cycle();
    check("rst.a.exc",   ifa.excepttype_o, 32'h0);
    check("rst.b.flush", 32'(ifb.flush_o), 32'h0);
    check("rst.b.newpc", ifb.new_pc_o,     32'h0);
    rst = 1'b0;
    idle_cycles(2);

    // Interrupt on a valid instruction with no flags
    status = 32'h0000FF01; cause = 32'h0000_0400; valid = 1;
    cycle();
    check("int.exc",   ifa.excepttype_o, 32'h1);
    check("int.flush", 32'(ifa.flush_o), 32'h1);
    check("int.newpc", ifa.new_pc_o,     32'h20);
    idle_cycles(4);

    // Interrupt not taken on a bubble
    status = 32'h0000FF01; cause = 32'h0000_0400; valid = 0;
    cycle();
    check("int.bubble", ifa.excepttype_o, 32'h0);
    idle_cycles(1);

    // syscall beats eret
    valid = 1; flags = 5'b10001; pc = 32'h100; ds = 1;
    cycle();
    check("sys.exc",  ifa.excepttype_o,            32'h8);
    check("sys.addr", ifa.current_inst_addr_o,     32'h100);
    check("sys.ds",   32'(ifa.is_in_delayslot_o),  32'h1);
    idle_cycles(4);

    // eret with EPC forwarded from WB, EXL set
    valid = 1; flags = 5'b00001; epc = 32'h40; status = 32'h2;
    we = 1; waddr = 5'd14; wdata = 32'h80;
    cycle();
    check("eret.exc",   ifa.excepttype_o, 32'he);
    check("eret.newpc", ifa.new_pc_o,     32'h80);
    idle_cycles(4);

    // overflow then trap on FLUSH_CYCLES=3: trap dropped
    valid = 1; flags = 5'b00010;
    cycle();
    check("ovf.exc",   ifb.excepttype_o, 32'hc);
    check("ovf.f1",    32'(ifb.flush_o), 32'h1);
    flags = 5'b00100;
    cycle();
    check("ovf.trap_dropped", ifb.excepttype_o, 32'h0);
    check("ovf.f2",           32'(ifb.flush_o), 32'h1);
    set_idle();
    cycle();
    check("ovf.f3",    32'(ifb.flush_o), 32'h1);
    check("ovf.npc3",  ifb.new_pc_o,     32'h20);
    cycle();
    check("ovf.f4",    32'(ifb.flush_o), 32'h0);
    idle_cycles(3);

    // stall holds off an invalid_inst for two cycles
    valid = 1; flags = 5'b01000; stall = 1;
    cycle();
    check("stall.c1", ifa.excepttype_o, 32'h0);
    cycle();
    check("stall.c2", 32'(ifa.flush_o), 32'h0);
    stall = 0;
    cycle();
    check("stall.exc", ifa.excepttype_o, 32'ha);
    idle_cycles(4);

    // reset in cycle 2 of a 3-cycle flush
    valid = 1; flags = 5'b10000;
    cycle();
    set_idle();
    cycle();
    check("rstfl.f2", 32'(ifb.flush_o), 32'h1);
    rst = 1;
    cycle();
    check("rstfl.flush", 32'(ifb.flush_o), 32'h0);
    check("rstfl.busy",  32'(ifb.busy_o),  32'h0);
    rst = 0;
    idle_cycles(2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] sel;
      rst   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 3) == 0);
      valid = ($urandom_range(0, 3) != 0);
      ds    = 1'($urandom);
      pc    = $urandom & 32'hFFFF_FFFC;
      flags = 5'd0;
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) flags[b] = 1'b1;
      status = $urandom;
      status[0] = ($urandom_range(0, 1) == 0);
      status[1] = ($urandom_range(0, 3) == 0);
      cause = $urandom_range(0, 1) ? $urandom : 32'h0;
      epc   = $urandom;
      we    = 1'($urandom);
      sel   = 2'($urandom);
      waddr = (sel == 2'd3) ? 5'($urandom) : 5'd12 + 5'(sel);
      wdata = $urandom;
      cycle();
    end
    rst = 0;
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exc_arbiter.md
EXC_ARBITER -- requirements
Module: exc_arbiter

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h00000020: redirect target for every exception except ERET.
REQ-002 Parameter FLUSH_CYCLES, default 1, range 1..15: number of cycles flush_o is held.
REQ-003 Reset is rst, synchronous, active-high; clock is clk.
REQ-004 Ports, in order: name  direction  width  meaning:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  stall_i  in  1  MEM stage stalled; no exception accepted
  inst_valid_i  in  1  MEM-stage instruction valid
  exc_flags_i  in  5  {syscall, invalid_inst, trap, overflow, eret}, bit4..bit0
  pc_i  in  32  MEM-stage instruction address
  is_in_delayslot_i  in  1  MEM instruction is in a delay slot
  cp0_status_i  in  32  CP0 Status (reg 12)
  cp0_cause_i  in  32  CP0 Cause (reg 13)
  cp0_epc_i  in  32  CP0 EPC (reg 14)
  wb_cp0_we_i  in  1  pending CP0 write in WB
  wb_cp0_waddr_i  in  5  pending CP0 write address
  wb_cp0_data_i  in  32  pending CP0 write data
  excepttype_o  out  32  exception code to CP0, one-cycle pulse
  current_inst_addr_o  out  32  faulting instruction address to CP0
  is_in_delayslot_o  out  1  delay-slot flag to CP0
  flush_o  out  1  pipeline flush
  new_pc_o  out  32  redirect address, valid while flush_o=1
  busy_o  out  1  FSM not in IDLE

Function
REQ-005 Forwarded Status: wb_data_i when we=1 and waddr=12, else cp0_status_i.
REQ-006 Forwarded Cause: cp0_cause_i with bits 9:8, 22, 23 replaced from wb data when we=1 and waddr=13; all other bits from cp0_cause_i.
REQ-007 Forwarded EPC: wb data when we=1 and waddr=14, else cp0_epc_i.
REQ-008 Interrupt pending = Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]), forwarded values.
REQ-009 Candidate exception exists only when inst_valid_i=1, stall_i=0, FSM=IDLE.
REQ-010 Priority, highest first: interrupt 32'h1, syscall 32'h8, invalid_inst 32'ha, trap 32'hd, overflow 32'hc, eret 32'he.
REQ-011 FSM states IDLE, FLUSH; IDLE->FLUSH on accepted candidate; FLUSH->IDLE after FLUSH_CYCLES cycles.
REQ-012 Candidate accepted at edge N: excepttype_o, current_inst_addr_o=pc_i, is_in_delayslot_o registered, valid cycle N+1 only.
REQ-013 excepttype_o = 0 in every cycle other than the one after acceptance.
REQ-014 flush_o = 1 for exactly FLUSH_CYCLES cycles starting cycle N+1; new_pc_o held constant over that window.
REQ-015 new_pc_o = forwarded EPC captured at acceptance for eret, EXC_VECTOR otherwise; 0 when flush_o=0.
REQ-016 While in FLUSH all inputs ignored; candidates in that window are dropped, not queued.
REQ-017 stall_i=1 with pending exception: nothing accepted, outputs unchanged; accepted first unstalled cycle.
REQ-018 busy_o = 1 iff FSM=FLUSH; flush counter 4 bits, reloads on every acceptance.
REQ-019 eret accepted regardless of Status[1]; interrupt never taken on inst_valid_i=0.

Reset
REQ-020 rst=1 at an edge: FSM=IDLE, counter=0, excepttype_o=0, current_inst_addr_o=0, is_in_delayslot_o=0, flush_o=0, new_pc_o=0, busy_o=0.
REQ-021 rst during FLUSH aborts the window; flush_o=0 the next cycle.

Structure
REQ-022 Exception codes, CP0 addresses 12/13/14, and FSM state encodings SHALL live in the shared defines package.
REQ-023 CP0 forwarding (REQ-005..007) SHALL be a sub-module exc_cp0_fwd; arbitration and FSM remain in exc_arbiter.

Verification
REQ-024 Status=32'h0000FF01, Cause[10]=1, valid, flags=0 -> next cycle excepttype_o=32'h1, flush_o=1, new_pc_o=32'h20.
REQ-025 flags=5'b10001 (syscall+eret), pc_i=32'h100, delayslot=1 -> excepttype_o=32'h8, current_inst_addr_o=32'h100, is_in_delayslot_o=1.
REQ-026 eret, cp0_epc_i=32'h40, WB write addr 14 data 32'h80 same cycle -> new_pc_o=32'h80.
REQ-027 FLUSH_CYCLES=3, overflow then trap next cycle -> flush_o high 3 cycles, single excepttype_o=32'hc pulse, trap dropped.
REQ-028 stall_i=1 for 2 cycles with invalid_inst -> no output; excepttype_o=32'ha the cycle after stall_i falls.
REQ-029 rst asserted cycle 2 of FLUSH_CYCLES=3 -> flush_o=0, busy_o=0 next cycle.
